mux8_32: RTL and testbench
==========================

MUX8_32 -- requirements
Module: mux8_32

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WORD_CNT_W, default 16, setting the width of the completed-word counter.
REQ-002 The block SHALL have parameter HOLD_LAST, default 1. 1 means lane_0 keeps its last word while valid_0 is low; 0 means lane_0 clears to 0 whenever valid_0 is low.

Ports (name, direction, width, meaning):
REQ-003 clk_4f, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 reset, input, 1: asynchronous, active-high reset.
REQ-005 data_in, input, 8: byte stream from the serial side.
REQ-006 valid_in, input, 1: data_in is valid in this cycle.
REQ-007 lane_0, output, 32: assembled word.
REQ-008 valid_0, output, 1: lane_0 holds a newly completed word.
REQ-009 partial_err, output, 1: one-cycle pulse when an incomplete word is discarded.
REQ-010 word_count, output, WORD_CNT_W: running count of completed words.

Function
REQ-011 Byte slot state SHALL be a 2-bit counter with states S0, S1, S2, S3, holding the number of bytes already collected.
REQ-012 A byte SHALL be accepted only on an edge where valid_in=1; there is no backpressure and every valid byte is accepted.
REQ-013 Byte placement SHALL be MSB-first: S0 -> [31:24], S1 -> [23:16], S2 -> [15:8], S3 -> [7:0].
REQ-014 On acceptance, state SHALL advance: S0->S1->S2->S3->S0.
REQ-015 Accepted bytes SHALL go into an internal 24-bit assembly register; lane_0 SHALL NOT change during S0-S2 collection.
REQ-016 On the edge accepting the S3 byte:
- lane_0 SHALL load {assembly[23:0], data_in};
- valid_0 SHALL go to 1;
- word_count SHALL increment.
REQ-017 Latency SHALL be 1 clk_4f cycle from the 4th byte on data_in to the word on lane_0 with valid_0=1.
REQ-018 valid_0 SHALL be a one-cycle pulse per completed word. Back-to-back words give valid_0 high in every 4th cycle, with lane_0 stable for 4 cycles.
REQ-019 On an edge with valid_0 low:
- HOLD_LAST=1: lane_0 SHALL keep its value;
- HOLD_LAST=0: lane_0 SHALL be 0.
REQ-020 valid_in=0 sampled in S0 SHALL leave the state at S0 with no other effect (idle gap between words).
REQ-021 valid_in=0 sampled in S1, S2 or S3 SHALL, on that edge:
- return the state to S0;
- clear the assembly register;
- pulse partial_err for one cycle;
- leave lane_0, valid_0 and word_count unchanged, apart from the valid_0 pulse timing of REQ-018.
REQ-022 After a discard, the next valid byte SHALL be treated as a new S0 byte.
REQ-023 word_count SHALL wrap from all-ones to 0 silently; wrap SHALL NOT set partial_err.
REQ-024 If valid_in stays 1 across word boundaries, there SHALL be no bubble: the byte in the cycle after the S3 byte is an S0 byte.

Reset
REQ-025 While reset=1, independent of clk_4f:
- state SHALL be S0;
- the assembly register SHALL be 0;
- lane_0=0, valid_0=0, partial_err=0, word_count=0.
REQ-026 Reset asserted mid-word SHALL discard collected bytes without pulsing partial_err.
REQ-027 Collection SHALL restart at S0 on the first edge with reset=0 and valid_in=1.

Verification
REQ-028 Bytes AA,BB,CC,DD on 4 consecutive cycles with valid_in=1 -> next cycle lane_0=AABBCCDD, valid_0=1 for 1 cycle, word_count=1.
REQ-029 8 continuous bytes 01..08 -> lane_0=01020304 then, 4 cycles later, 05060708; valid_0 pulses exactly twice, 4 cycles apart, word_count=2.
REQ-030 Bytes 11,22 then valid_in=0, then 33,44,55,66 -> partial_err pulses once; next word is 33445566; 11/22 never appear.
REQ-031 Gap test: word 0A0B0C0D, 3 idle cycles, word 01020304 -> no partial_err; HOLD_LAST=1 holds 0A0B0C0D during the gap; HOLD_LAST=0 shows 0 during the gap.
REQ-032 reset pulsed mid-clock after 3 bytes -> all outputs 0 immediately; subsequent bytes 44,55,66,77 -> 44556677, no partial_err.
REQ-033 WORD_CNT_W=2: 5 words -> word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/mux8_32_if.sv
// Byte-stream to 32-bit word assembler bus.
// master: drives data_in/valid_in and observes the assembled-word outputs.
// slave : the assembler side.
//   data_in     8-bit byte from the serial side
//   valid_in    data_in valid this cycle
//   lane_0      assembled 32-bit word
//   valid_0     lane_0 holds a newly completed word (one-cycle pulse)
//   partial_err one-cycle pulse when an incomplete word is discarded
//   word_count  running count of completed words
interface mux8_32_if #(
  parameter int unsigned WORD_CNT_W = 16
);
  logic [7:0]            data_in;
  logic                  valid_in;
  logic [31:0]           lane_0;
  logic                  valid_0;
  logic                  partial_err;
  logic [WORD_CNT_W-1:0] word_count;

  modport master (
    output data_in, valid_in,
    input  lane_0, valid_0, partial_err, word_count
  );

  modport slave (
    input  data_in, valid_in,
    output lane_0, valid_0, partial_err, word_count
  );
endinterface

// File: rtl/mux8_32.sv
// Collects four consecutive valid bytes (MSB first) into a 32-bit word.
// A missing byte mid-word discards the partial word and pulses partial_err.
// Ports:
//   clk_4f  single clock, rising edge
//   reset   asynchronous, active-high
//   bus     mux8_32_if slave: data_in/valid_in in; lane_0, valid_0,
//           partial_err, word_count out
// Parameters:
//   WORD_CNT_W  width of the completed-word counter
//   HOLD_LAST   1: lane_0 holds its last word; 0: lane_0 is 0 while valid_0 low
module mux8_32 #(
  parameter int unsigned WORD_CNT_W = 16,
  parameter int unsigned HOLD_LAST  = 1
) (
  input logic      clk_4f,
  input logic      reset,
  mux8_32_if.slave bus
);

  // Number of bytes already collected for the current word.
  typedef enum logic [1:0] {S0, S1, S2, S3} slot_e;

  slot_e                 state_q, state_d;
  logic [23:0]           asm_q, asm_d;
  logic [31:0]           lane_q, lane_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    lane_d  = (HOLD_LAST != 0) ? lane_q : 32'h0;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    cnt_d   = cnt_q;

    if (bus.valid_in) begin
      unique case (state_q)
        S0: begin
          asm_d   = {bus.data_in, 16'h0};
          state_d = S1;
        end
        S1: begin
          asm_d[15:8] = bus.data_in;
          state_d     = S2;
        end
        S2: begin
          asm_d[7:0] = bus.data_in;
          state_d    = S3;
        end
        S3: begin
          // Fourth byte goes straight to the lane; it never lands in asm.
          lane_d  = {asm_q, bus.data_in};
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          asm_d   = 24'h0;
          state_d = S0;
        end
      endcase
    end else if (state_q != S0) begin
      // Gap inside a word: drop what was collected.
      state_d = S0;
      asm_d   = 24'h0;
      perr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      asm_q   <= 24'h0;
      lane_q  <= 32'h0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.lane_0      = lane_q;
  assign bus.valid_0     = valid_q;
  assign bus.partial_err = perr_q;
  assign bus.word_count  = cnt_q;

endmodule

// File: tb/tb_mux8_32.sv
// Directed bench for mux8_32: three instances (default, HOLD_LAST=0,
// WORD_CNT_W=2) fed the same byte stream.
module tb_mux8_32;

  logic       clk_4f;
  logic       reset;
  logic [7:0] data;
  logic       valid;

  mux8_32_if #(.WORD_CNT_W(16)) bus_a ();
  mux8_32_if #(.WORD_CNT_W(16)) bus_h ();
  mux8_32_if #(.WORD_CNT_W(2))  bus_w ();

  assign bus_a.data_in  = data;
  assign bus_a.valid_in = valid;
  assign bus_h.data_in  = data;
  assign bus_h.valid_in = valid;
  assign bus_w.data_in  = data;
  assign bus_w.valid_in = valid;

  mux8_32 #(.WORD_CNT_W(16), .HOLD_LAST(1)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_a)
  );

  mux8_32 #(.WORD_CNT_W(16), .HOLD_LAST(0)) dut_h0 (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_h)
  );

  mux8_32 #(.WORD_CNT_W(2), .HOLD_LAST(1)) dut_w2 (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_w)
  );

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  int          n_vec;
  int          n_err;
  int          exp_cnt;
  logic [31:0] last_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
    step();
  endtask

  // Four consecutive valid bytes, checking the outputs after every edge.
  task automatic send_word(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      drive(1'b1, b);
      if (i < 3) begin
        check_eq("lane_hold", bus_a.lane_0, last_word);
        check_eq("valid_low", 32'(bus_a.valid_0), 32'd0);
        check_eq("h0_lane_zero", bus_h.lane_0, 32'h0);
        check_eq("perr_low", 32'(bus_a.partial_err), 32'd0);
      end else begin
        exp_cnt++;
        last_word = w;
        check_eq("lane_word", bus_a.lane_0, w);
        check_eq("valid_pulse", 32'(bus_a.valid_0), 32'd1);
        check_eq("word_count", 32'(bus_a.word_count), 32'(exp_cnt));
        check_eq("perr_low_end", 32'(bus_a.partial_err), 32'd0);
        check_eq("h0_lane_word", bus_h.lane_0, w);
        check_eq("w2_count", 32'(bus_w.word_count), 32'(exp_cnt % 4));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_lane"}, bus_a.lane_0, 32'h0);
    check_eq({tag, "_valid"}, 32'(bus_a.valid_0), 32'd0);
    check_eq({tag, "_perr"}, 32'(bus_a.partial_err), 32'd0);
    check_eq({tag, "_count"}, 32'(bus_a.word_count), 32'd0);
    check_eq({tag, "_h0_lane"}, bus_h.lane_0, 32'h0);
    check_eq({tag, "_w2_count"}, 32'(bus_w.word_count), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_cnt   = 0;
    last_word = 32'h0;
    reset     = 1'b1;
    valid     = 1'b0;
    data      = 8'h00;
    #12;
    check_zero("reset");
    reset = 1'b0;

    // Single word, then one idle cycle.
    send_word(32'hAABBCCDD);
    drive(1'b0, 8'h00);
    check_eq("idle_valid", 32'(bus_a.valid_0), 32'd0);
    check_eq("idle_lane_hold", bus_a.lane_0, 32'hAABBCCDD);
    check_eq("idle_h0_lane", bus_h.lane_0, 32'h0);
    check_eq("idle_perr", 32'(bus_a.partial_err), 32'd0);

    // Two words back-to-back without a bubble.
    send_word(32'h01020304);
    send_word(32'h05060708);

    // Partial word discarded.
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b0, 8'h00);
    check_eq("discard_perr", 32'(bus_a.partial_err), 32'd1);
    check_eq("discard_lane", bus_a.lane_0, 32'h05060708);
    check_eq("discard_valid", 32'(bus_a.valid_0), 32'd0);
    check_eq("discard_count", 32'(bus_a.word_count), 32'(exp_cnt));
    send_word(32'h33445566);

    // Idle gap between words is not an error.
    send_word(32'h0A0B0C0D);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00);
      check_eq("gap_perr", 32'(bus_a.partial_err), 32'd0);
      check_eq("gap_lane_hold", bus_a.lane_0, 32'h0A0B0C0D);
      check_eq("gap_h0_lane", bus_h.lane_0, 32'h0);
    end
    send_word(32'h01020304);

    // Asynchronous reset mid-cycle after three bytes.
    drive(1'b1, 8'hE1);
    drive(1'b1, 8'hE2);
    drive(1'b1, 8'hE3);
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    #1 reset = 1'b0;
    exp_cnt   = 0;
    last_word = 32'h0;
    send_word(32'h44556677);
    drive(1'b0, 8'h00);
    check_eq("post_reset_perr", 32'(bus_a.partial_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
